axil_cmd_master: RTL and testbench
==================================

# axil_cmd_master

Synthesizable, parametrised AXI-Lite master that executes single-beat read, write and poll commands from a valid/ready command port and returns one response per command. It replaces hand-driven AXI-Lite read/write sequencing toward the accelerator control/status registers (`Usr_Logic` status at 0x1000). It also adds hardware polling, so an on-chip sequencer can wait for accelerator completion without a host in the loop.

## Interface
Parameters:
- AXIL_AW, 32, AXI-Lite address width
- AXIL_DW, 32, AXI-Lite data width (multiple of 8)
- POLL_MAX, 256, maximum read attempts per poll command (≥1)
- POLL_GAP, 4, idle cycles between poll attempts (≥0)
- WDOG_CYC, 1024, watchdog limit in cycles (used only with the macro)

Ports:
- user_clk  in  1  sole clock
- user_reset  in  1  synchronous, active-high reset
- cmd_valid  in  1  command valid
- cmd_ready  out  1  command accepted when valid&ready
- cmd_op  in  2  0=READ, 1=WRITE, 2=POLL, 3=reserved (behaves as READ)
- cmd_addr  in  AXIL_AW  target address
- cmd_data  in  AXIL_DW  write data / poll expected value
- cmd_mask  in  AXIL_DW  poll compare mask
- cmd_strb  in  AXIL_DW/8  write strobes
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response accepted
- rsp_data  out  AXIL_DW  last read data (0 for WRITE)
- rsp_status  out  2  00=OK, 01=AXI error, 10=poll exhausted
- rsp_attempts  out  16  read count used by a POLL (1 for READ, 0 for WRITE)
- busy  out  1  high in any state other than IDLE
- wdog_err  out  1  sticky watchdog flag
- m_axil_aw*/w*/b*/ar*/r*  standard AXI-Lite master channels, AXIL_AW/AXIL_DW wide; awprot/arprot tied 3'b000

## Operation
- FSM states: IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA, POLL_GAP_WAIT, RSP.
- IDLE: cmd_ready=1. On handshake, latch all cmd fields and go to WR_ADDR_DATA (WRITE) or RD_ADDR (READ/POLL). Clear the attempt counter to 0.
- WR_ADDR_DATA: awvalid and wvalid are asserted together. Each drops independently on its own handshake, so AW before W, W before AW and both in the same cycle are all legal. After both handshakes, go to WR_RESP.
- WR_RESP: bready=1. On the B handshake, status = (bresp!=0) ? 01 : 00. Go to RSP.
- RD_ADDR: arvalid=1 until arready. Increment the attempt counter on the AR handshake, then go to RD_DATA.
- RD_DATA: rready=1. On the R handshake, capture rdata.
  - rresp!=0 → status 01, go to RSP. This aborts any poll.
  - READ → status 00, go to RSP.
  - POLL with (rdata & mask)==(data & mask) → status 00, go to RSP.
  - POLL miss with attempts==POLL_MAX → status 10, go to RSP.
  - POLL miss otherwise → go to POLL_GAP_WAIT. If POLL_GAP==0, go directly to RD_ADDR.
- POLL_GAP_WAIT: count POLL_GAP cycles, then go to RD_ADDR.
- RSP: rsp_valid=1 and all payload is held stable until rsp_ready. On handshake, go to IDLE.
- Only one transaction is ever outstanding.
- Arithmetic:
  - The attempt counter is 16 bits.
  - POLL_MAX > 65535 is illegal; a synthesis-time assertion enforces it.

## Timing
- Reset values: all outputs 0 except cmd_ready=1. FSM in IDLE, wdog_err=0.
- All AXI and rsp outputs are registered.
- Valid signals rise in the cycle after the command handshake.
- Best-case latency, command handshake to rsp_valid:
  - WRITE: 3 cycles (AW/W accepted in the first cycle, B the next).
  - READ: 3 cycles.
- Each POLL retry costs 2 + POLL_GAP cycles minimum.
- rsp_valid stays asserted until rsp_ready; back-to-back commands are not accepted while in RSP.
- No combinational path exists from any input to cmd_ready or to the AXI valid outputs.
- Reset asserted mid-transaction: all valids drop the next edge and the FSM returns to IDLE. The slave must share user_reset.

## Configuration
- AXIL_CMD_MASTER_WDOG_EN defined:
  - A cycle counter runs in WR_ADDR_DATA, WR_RESP, RD_ADDR and RD_DATA, and clears on every AXI handshake.
  - Reaching WDOG_CYC sets wdog_err (sticky until user_reset).
  - The FSM keeps waiting; no AXI abort is performed.
- Not defined: no counter logic; wdog_err is tied 0.

## Test plan
- WRITE 0xDEADBEEF to 0x1004 (strb 0xF), slave zero-wait: awvalid/wvalid seen one cycle after cmd handshake, rsp_status=00, rsp_data=0, rsp_valid 3 cycles after command.
- Slave accepts W two cycles before AW: exactly one W and one AW beat, wvalid low after its handshake, rsp_status=00.
- POLL 0x1000, mask 0x1, data 0x1; slave returns 0,0,1: rsp_status=00, rsp_attempts=3, rsp_data=0x1, POLL_GAP idle cycles observed between reads.
- POLL with POLL_MAX=4, slave always returns 0: exactly 4 AR beats, rsp_status=10, rsp_attempts=4.
- READ with rresp=SLVERR, rsp_ready held low 5 cycles: rsp_status=01, payload stable, cmd_ready=0 until the rsp handshake.
- With AXIL_CMD_MASTER_WDOG_EN and WDOG_CYC=16, arready never asserted: wdog_err=1 after 16 cycles and remains 1. user_reset clears it and returns all outputs to their reset values.

Source files
------------

// File: rtl/axil_cmd_master.sv
// axil_cmd_master: single-beat AXI-Lite master executing READ / WRITE / POLL commands.
// Define AXIL_CMD_MASTER_WDOG_EN to add a sticky stall watchdog on wdog_err.
module axil_cmd_master #(
  parameter int AXIL_AW  = 32,
  parameter int AXIL_DW  = 32,
  parameter int POLL_MAX = 256,
  parameter int POLL_GAP = 4,
  parameter int WDOG_CYC = 1024
) (
  input  logic                 user_clk,
  input  logic                 user_reset,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [1:0]           cmd_op,
  input  logic [AXIL_AW-1:0]   cmd_addr,
  input  logic [AXIL_DW-1:0]   cmd_data,
  input  logic [AXIL_DW-1:0]   cmd_mask,
  input  logic [AXIL_DW/8-1:0] cmd_strb,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [AXIL_DW-1:0]   rsp_data,
  output logic [1:0]           rsp_status,
  output logic [15:0]          rsp_attempts,
  output logic                 busy,
  output logic                 wdog_err,
  output logic [AXIL_AW-1:0]   m_axil_awaddr,
  output logic [2:0]           m_axil_awprot,
  output logic                 m_axil_awvalid,
  input  logic                 m_axil_awready,
  output logic [AXIL_DW-1:0]   m_axil_wdata,
  output logic [AXIL_DW/8-1:0] m_axil_wstrb,
  output logic                 m_axil_wvalid,
  input  logic                 m_axil_wready,
  input  logic [1:0]           m_axil_bresp,
  input  logic                 m_axil_bvalid,
  output logic                 m_axil_bready,
  output logic [AXIL_AW-1:0]   m_axil_araddr,
  output logic [2:0]           m_axil_arprot,
  output logic                 m_axil_arvalid,
  input  logic                 m_axil_arready,
  input  logic [AXIL_DW-1:0]   m_axil_rdata,
  input  logic [1:0]           m_axil_rresp,
  input  logic                 m_axil_rvalid,
  output logic                 m_axil_rready
);

  if (POLL_MAX < 1 || POLL_MAX > 65535) begin : g_bad_poll_max
    $error("axil_cmd_master: POLL_MAX must lie in 1..65535");
  end
  if (POLL_GAP < 0 || WDOG_CYC < 1) begin : g_bad_cfg
    $error("axil_cmd_master: POLL_GAP must be >= 0 and WDOG_CYC >= 1");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_WR_ADDR_DATA, S_WR_RESP, S_RD_ADDR, S_RD_DATA, S_POLL_GAP_WAIT, S_RSP
  } state_t;

  localparam logic [1:0]  OP_WRITE   = 2'd1;
  localparam logic [1:0]  OP_POLL    = 2'd2;
  localparam logic [1:0]  ST_OK      = 2'b00;
  localparam logic [1:0]  ST_AXI_ERR = 2'b01;
  localparam logic [1:0]  ST_POLL_EX = 2'b10;
  localparam logic [15:0] ATT_MAX    = 16'(POLL_MAX);
  localparam logic [15:0] GAP_LAST   = (POLL_GAP > 0) ? 16'(POLL_GAP - 1) : 16'd0;

  state_t               state_q, state_d;
  logic [1:0]           op_q, op_d;
  logic [AXIL_AW-1:0]   addr_q, addr_d;
  logic [AXIL_DW-1:0]   data_q, data_d;
  logic [AXIL_DW-1:0]   mask_q, mask_d;
  logic [AXIL_DW/8-1:0] strb_q, strb_d;
  logic [15:0]          attempts_q, attempts_d;
  logic [15:0]          gap_cnt_q, gap_cnt_d;
  logic                 cmd_ready_q, cmd_ready_d;
  logic                 busy_q, busy_d;
  logic                 awvalid_q, awvalid_d;
  logic                 wvalid_q, wvalid_d;
  logic                 bready_q, bready_d;
  logic                 arvalid_q, arvalid_d;
  logic                 rready_q, rready_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [AXIL_DW-1:0]   rsp_data_q, rsp_data_d;
  logic [1:0]           rsp_status_q, rsp_status_d;
  logic                 aw_done, w_done, poll_hit;

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    addr_d       = addr_q;
    data_d       = data_q;
    mask_d       = mask_q;
    strb_d       = strb_q;
    attempts_d   = attempts_q;
    gap_cnt_d    = gap_cnt_q;
    awvalid_d    = awvalid_q;
    wvalid_d     = wvalid_q;
    bready_d     = bready_q;
    arvalid_d    = arvalid_q;
    rready_d     = rready_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_data_d   = rsp_data_q;
    rsp_status_d = rsp_status_q;
    aw_done      = !awvalid_q || m_axil_awready;
    w_done       = !wvalid_q || m_axil_wready;
    poll_hit     = ((m_axil_rdata ^ data_q) & mask_q) == '0;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          op_d       = cmd_op;
          addr_d     = cmd_addr;
          data_d     = cmd_data;
          mask_d     = cmd_mask;
          strb_d     = cmd_strb;
          attempts_d = '0;
          if (cmd_op == OP_WRITE) begin
            state_d   = S_WR_ADDR_DATA;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else begin
            state_d   = S_RD_ADDR;
            arvalid_d = 1'b1;
          end
        end
      end
      // AW and W retire independently; move on once both have been accepted.
      S_WR_ADDR_DATA: begin
        if (awvalid_q && m_axil_awready) awvalid_d = 1'b0;
        if (wvalid_q && m_axil_wready)   wvalid_d  = 1'b0;
        if (aw_done && w_done) begin
          state_d  = S_WR_RESP;
          bready_d = 1'b1;
        end
      end
      S_WR_RESP: begin
        if (m_axil_bvalid) begin
          bready_d     = 1'b0;
          rsp_data_d   = '0;
          rsp_status_d = (m_axil_bresp != 2'b00) ? ST_AXI_ERR : ST_OK;
          rsp_valid_d  = 1'b1;
          state_d      = S_RSP;
        end
      end
      S_RD_ADDR: begin
        if (m_axil_arready) begin
          arvalid_d  = 1'b0;
          attempts_d = attempts_q + 16'd1;
          rready_d   = 1'b1;
          state_d    = S_RD_DATA;
        end
      end
      S_RD_DATA: begin
        if (m_axil_rvalid) begin
          rready_d   = 1'b0;
          rsp_data_d = m_axil_rdata;
          if (m_axil_rresp != 2'b00) begin
            rsp_status_d = ST_AXI_ERR;
            rsp_valid_d  = 1'b1;
            state_d      = S_RSP;
          end else if (op_q != OP_POLL || poll_hit) begin
            rsp_status_d = ST_OK;
            rsp_valid_d  = 1'b1;
            state_d      = S_RSP;
          end else if (attempts_q == ATT_MAX) begin
            rsp_status_d = ST_POLL_EX;
            rsp_valid_d  = 1'b1;
            state_d      = S_RSP;
          end else if (POLL_GAP == 0) begin
            arvalid_d = 1'b1;
            state_d   = S_RD_ADDR;
          end else begin
            gap_cnt_d = '0;
            state_d   = S_POLL_GAP_WAIT;
          end
        end
      end
      S_POLL_GAP_WAIT: begin
        if (gap_cnt_q == GAP_LAST) begin
          arvalid_d = 1'b1;
          state_d   = S_RD_ADDR;
        end else begin
          gap_cnt_d = gap_cnt_q + 16'd1;
        end
      end
      S_RSP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Registering these from the next state keeps cmd_ready free of input paths.
    cmd_ready_d = (state_d == S_IDLE);
    busy_d      = (state_d != S_IDLE);
  end

  always_ff @(posedge user_clk) begin
    if (user_reset) begin
      state_q      <= S_IDLE;
      op_q         <= '0;
      addr_q       <= '0;
      data_q       <= '0;
      mask_q       <= '0;
      strb_q       <= '0;
      attempts_q   <= '0;
      gap_cnt_q    <= '0;
      cmd_ready_q  <= 1'b1;
      busy_q       <= 1'b0;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      bready_q     <= 1'b0;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
      rsp_status_q <= '0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      mask_q       <= mask_d;
      strb_q       <= strb_d;
      attempts_q   <= attempts_d;
      gap_cnt_q    <= gap_cnt_d;
      cmd_ready_q  <= cmd_ready_d;
      busy_q       <= busy_d;
      awvalid_q    <= awvalid_d;
      wvalid_q     <= wvalid_d;
      bready_q     <= bready_d;
      arvalid_q    <= arvalid_d;
      rready_q     <= rready_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      rsp_status_q <= rsp_status_d;
    end
  end

`ifdef AXIL_CMD_MASTER_WDOG_EN
  logic [31:0] wdog_cnt_q, wdog_cnt_d;
  logic        wdog_err_q, wdog_err_d;
  logic        wdog_run, axi_hs;

  // Counts stalled cycles while waiting on the slave; any handshake restarts it.
  always_comb begin
    axi_hs = (awvalid_q && m_axil_awready) || (wvalid_q && m_axil_wready) ||
             (bready_q && m_axil_bvalid) || (arvalid_q && m_axil_arready) ||
             (rready_q && m_axil_rvalid);
    wdog_run = (state_q == S_WR_ADDR_DATA) || (state_q == S_WR_RESP) ||
               (state_q == S_RD_ADDR) || (state_q == S_RD_DATA);
    wdog_cnt_d = '0;
    if (wdog_run && !axi_hs) begin
      wdog_cnt_d = (wdog_cnt_q == 32'(WDOG_CYC)) ? wdog_cnt_q : wdog_cnt_q + 32'd1;
    end
    wdog_err_d = wdog_err_q || (wdog_cnt_d == 32'(WDOG_CYC));
  end

  always_ff @(posedge user_clk) begin
    if (user_reset) begin
      wdog_cnt_q <= '0;
      wdog_err_q <= 1'b0;
    end else begin
      wdog_cnt_q <= wdog_cnt_d;
      wdog_err_q <= wdog_err_d;
    end
  end

  assign wdog_err = wdog_err_q;
`else
  assign wdog_err = 1'b0;
`endif

  assign cmd_ready      = cmd_ready_q;
  assign busy           = busy_q;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_data       = rsp_data_q;
  assign rsp_status     = rsp_status_q;
  assign rsp_attempts   = attempts_q;
  assign m_axil_awaddr  = addr_q;
  assign m_axil_awprot  = 3'b000;
  assign m_axil_awvalid = awvalid_q;
  assign m_axil_wdata   = data_q;
  assign m_axil_wstrb   = strb_q;
  assign m_axil_wvalid  = wvalid_q;
  assign m_axil_bready  = bready_q;
  assign m_axil_araddr  = addr_q;
  assign m_axil_arprot  = 3'b000;
  assign m_axil_arvalid = arvalid_q;
  assign m_axil_rready  = rready_q;

endmodule

// File: tb/tb_axil_cmd_master.sv
// Scoreboard bench for axil_cmd_master with a small registered AXI-Lite slave model.
// Watchdog checks follow AXIL_CMD_MASTER_WDOG_EN; otherwise wdog_err must stay 0.
module tb_axil_cmd_master;
  localparam int POLL_MAX = 4;
  localparam int POLL_GAP = 4;
  localparam int WDOG_CYC = 16;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  status;
    logic [15:0] attempts;
  } exp_t;

  logic        user_clk = 1'b0;
  logic        user_reset = 1'b1;
  logic        cmd_valid = 1'b0, cmd_ready;
  logic [1:0]  cmd_op = '0;
  logic [31:0] cmd_addr = '0, cmd_data = '0, cmd_mask = '0;
  logic [3:0]  cmd_strb = '0;
  logic        rsp_valid, rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_status;
  logic [15:0] rsp_attempts;
  logic        busy, wdog_err;
  logic [31:0] m_axil_awaddr, m_axil_wdata, m_axil_araddr, m_axil_rdata = '0;
  logic [2:0]  m_axil_awprot, m_axil_arprot;
  logic        m_axil_awvalid, m_axil_awready = 1'b1;
  logic [3:0]  m_axil_wstrb;
  logic        m_axil_wvalid, m_axil_wready = 1'b1;
  logic [1:0]  m_axil_bresp = '0, m_axil_rresp = '0;
  logic        m_axil_bvalid = 1'b0, m_axil_bready;
  logic        m_axil_arvalid, m_axil_arready = 1'b1;
  logic        m_axil_rvalid = 1'b0, m_axil_rready;

  int          cmpCount = 0;
  int          errCount = 0;
  exp_t        sb[$];
  logic [31:0] rdQueue[$];
  int          arCyc[$];
  int          cyc = 0, awBeats = 0, wBeats = 0, arBeats = 0;
  logic        awSeen = 1'b0, wSeen = 1'b0;
  logic [1:0]  slvBresp = 2'b00, slvRresp = 2'b00;

  axil_cmd_master #(
    .AXIL_AW(32), .AXIL_DW(32), .POLL_MAX(POLL_MAX), .POLL_GAP(POLL_GAP), .WDOG_CYC(WDOG_CYC)
  ) dut (
    .user_clk(user_clk), .user_reset(user_reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_addr(cmd_addr),
    .cmd_data(cmd_data), .cmd_mask(cmd_mask), .cmd_strb(cmd_strb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_status(rsp_status), .rsp_attempts(rsp_attempts), .busy(busy), .wdog_err(wdog_err),
    .m_axil_awaddr(m_axil_awaddr), .m_axil_awprot(m_axil_awprot),
    .m_axil_awvalid(m_axil_awvalid), .m_axil_awready(m_axil_awready),
    .m_axil_wdata(m_axil_wdata), .m_axil_wstrb(m_axil_wstrb),
    .m_axil_wvalid(m_axil_wvalid), .m_axil_wready(m_axil_wready),
    .m_axil_bresp(m_axil_bresp), .m_axil_bvalid(m_axil_bvalid), .m_axil_bready(m_axil_bready),
    .m_axil_araddr(m_axil_araddr), .m_axil_arprot(m_axil_arprot),
    .m_axil_arvalid(m_axil_arvalid), .m_axil_arready(m_axil_arready),
    .m_axil_rdata(m_axil_rdata), .m_axil_rresp(m_axil_rresp),
    .m_axil_rvalid(m_axil_rvalid), .m_axil_rready(m_axil_rready)
  );

  always #5 user_clk = ~user_clk;

  // Registered slave: B follows once both AW and W were taken, R follows each AR.
  always @(posedge user_clk) begin
    cyc <= cyc + 1;
    if (user_reset) begin
      m_axil_bvalid <= 1'b0;
      m_axil_rvalid <= 1'b0;
      awSeen        <= 1'b0;
      wSeen         <= 1'b0;
    end else begin
      if (m_axil_awvalid && m_axil_awready) awBeats <= awBeats + 1;
      if (m_axil_wvalid && m_axil_wready)   wBeats  <= wBeats + 1;
      if ((awSeen || (m_axil_awvalid && m_axil_awready)) &&
          (wSeen || (m_axil_wvalid && m_axil_wready))) begin
        m_axil_bvalid <= 1'b1;
        m_axil_bresp  <= slvBresp;
        awSeen        <= 1'b0;
        wSeen         <= 1'b0;
      end else begin
        awSeen <= awSeen || (m_axil_awvalid && m_axil_awready);
        wSeen  <= wSeen || (m_axil_wvalid && m_axil_wready);
      end
      if (m_axil_bvalid && m_axil_bready) m_axil_bvalid <= 1'b0;
      if (m_axil_arvalid && m_axil_arready) begin
        arBeats <= arBeats + 1;
        arCyc.push_back(cyc);
        m_axil_rvalid <= 1'b1;
        m_axil_rresp  <= slvRresp;
        if (rdQueue.size() > 0) m_axil_rdata <= rdQueue.pop_front();
        else                    m_axil_rdata <= 32'h0;
      end
      if (m_axil_rvalid && m_axil_rready) m_axil_rvalid <= 1'b0;
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] act, input logic [63:0] expv);
    cmpCount++;
    if (act !== expv) begin
      errCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, act, expv);
    end
  endtask

  // Drives one command and returns just after its handshake edge.
  task automatic applyStimulus(input logic [1:0] op, input logic [31:0] addr,
                               input logic [31:0] data, input logic [31:0] mask,
                               input logic [3:0] strb, input bit push, input exp_t e);
    int waitCnt = 0;
    @(negedge user_clk);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = addr;
    cmd_data  = data;
    cmd_mask  = mask;
    cmd_strb  = strb;
    if (push) sb.push_back(e);
    while (!cmd_ready && waitCnt < 50) begin
      @(negedge user_clk);
      waitCnt++;
    end
    if (!cmd_ready) checkOutput("cmd_ready_timeout", 0, 1);
    @(posedge user_clk);
    #1 cmd_valid = 1'b0;
  endtask

  // Waits for rsp_valid, optionally stalls rsp_ready, then pops and compares.
  task automatic waitResponse(input int start, input int hold, output int lat);
    bit          found = 0;
    logic [31:0] d0;
    logic [1:0]  s0;
    logic [15:0] a0;
    exp_t        e;
    lat = start;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge user_clk);
      lat++;
      if (rsp_valid) found = 1;
    end
    if (!found) begin
      checkOutput("rsp_timeout", 0, 1);
      if (sb.size() > 0) void'(sb.pop_front());
      return;
    end
    d0 = rsp_data; s0 = rsp_status; a0 = rsp_attempts;
    for (int i = 0; i < hold; i++) begin
      checkOutput("cmd_ready_in_rsp", cmd_ready, 0);
      @(negedge user_clk);
      checkOutput("rsp_valid_hold", rsp_valid, 1);
      checkOutput("rsp_data_hold", rsp_data, d0);
      checkOutput("rsp_status_hold", rsp_status, s0);
      checkOutput("rsp_attempts_hold", rsp_attempts, a0);
    end
    if (sb.size() == 0) begin
      checkOutput("sb_empty", 1, 0);
    end else begin
      e = sb.pop_front();
      checkOutput("rsp_data", rsp_data, e.data);
      checkOutput("rsp_status", rsp_status, e.status);
      checkOutput("rsp_attempts", rsp_attempts, e.attempts);
    end
    rsp_ready = 1'b1;
    @(posedge user_clk);
    #1 rsp_ready = 1'b0;
    @(negedge user_clk);
    checkOutput("rsp_valid_drop", rsp_valid, 0);
    checkOutput("cmd_ready_back", cmd_ready, 1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "[TB] simulation timeout");
  end

  initial begin
    exp_t e;
    int   lat, b0, w0, k, firstErr;
    logic [31:0] d;
    logic [31:0] a;
    logic [1:0]  op;

    repeat (3) @(negedge user_clk);
    checkOutput("rst_cmd_ready", cmd_ready, 1);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_rsp_valid", rsp_valid, 0);
    checkOutput("rst_valids", {m_axil_awvalid, m_axil_wvalid, m_axil_arvalid}, 0);
    checkOutput("rst_wdog", wdog_err, 0);
    user_reset = 1'b0;

    $display("[TB] zero-wait WRITE");
    e = '{data: 32'h0, status: 2'b00, attempts: 16'd0};
    applyStimulus(2'd1, 32'h1004, 32'hDEADBEEF, 32'h0, 4'hF, 1, e);
    @(negedge user_clk);
    checkOutput("wr_awvalid", m_axil_awvalid, 1);
    checkOutput("wr_wvalid", m_axil_wvalid, 1);
    checkOutput("wr_awaddr", m_axil_awaddr, 32'h1004);
    checkOutput("wr_wdata", m_axil_wdata, 32'hDEADBEEF);
    checkOutput("wr_wstrb", m_axil_wstrb, 4'hF);
    checkOutput("wr_prot", {m_axil_awprot, m_axil_arprot}, 0);
    checkOutput("wr_busy", busy, 1);
    waitResponse(1, 0, lat);
    checkOutput("wr_latency", lat, 3);
    checkOutput("wr_aw_beats", awBeats, 1);
    checkOutput("wr_w_beats", wBeats, 1);

    $display("[TB] W accepted before AW");
    b0 = awBeats; w0 = wBeats;
    m_axil_awready = 1'b0;
    e = '{data: 32'h0, status: 2'b00, attempts: 16'd0};
    applyStimulus(2'd1, 32'h2000, 32'h12345678, 32'h0, 4'h3, 1, e);
    @(negedge user_clk);
    @(negedge user_clk);
    checkOutput("wfirst_wvalid_low", m_axil_wvalid, 0);
    checkOutput("wfirst_awvalid_high", m_axil_awvalid, 1);
    @(negedge user_clk);
    m_axil_awready = 1'b1;
    waitResponse(3, 0, lat);
    checkOutput("wfirst_aw_beats", awBeats - b0, 1);
    checkOutput("wfirst_w_beats", wBeats - w0, 1);

    $display("[TB] WRITE with SLVERR");
    slvBresp = 2'b10;
    e = '{data: 32'h0, status: 2'b01, attempts: 16'd0};
    applyStimulus(2'd1, 32'h3000, 32'hA5A5A5A5, 32'h0, 4'h1, 1, e);
    waitResponse(0, 0, lat);
    slvBresp = 2'b00;

    $display("[TB] READ and reserved op");
    rdQueue.push_back(32'hCAFE0001);
    e = '{data: 32'hCAFE0001, status: 2'b00, attempts: 16'd1};
    applyStimulus(2'd0, 32'h1000, 32'h0, 32'h0, 4'h0, 1, e);
    @(negedge user_clk);
    checkOutput("rd_araddr", m_axil_araddr, 32'h1000);
    checkOutput("rd_arvalid", m_axil_arvalid, 1);
    waitResponse(1, 0, lat);
    checkOutput("rd_latency", lat, 3);
    rdQueue.push_back(32'h55AA0003);
    e = '{data: 32'h55AA0003, status: 2'b00, attempts: 16'd1};
    applyStimulus(2'd3, 32'h1008, 32'h0, 32'h0, 4'h0, 1, e);
    waitResponse(0, 0, lat);
    checkOutput("op3_latency", lat, 3);

    $display("[TB] POLL hit on third read");
    arCyc.delete();
    rdQueue.push_back(32'h00000010);
    rdQueue.push_back(32'h00000000);
    rdQueue.push_back(32'h0000F0F1);
    e = '{data: 32'h0000F0F1, status: 2'b00, attempts: 16'd3};
    applyStimulus(2'd2, 32'h1000, 32'h1, 32'h1, 4'h0, 1, e);
    waitResponse(0, 0, lat);
    checkOutput("poll_ar_count", arCyc.size(), 3);
    if (arCyc.size() == 3) begin
      checkOutput("poll_gap1", arCyc[1] - arCyc[0], 2 + POLL_GAP);
      checkOutput("poll_gap2", arCyc[2] - arCyc[1], 2 + POLL_GAP);
    end

    $display("[TB] POLL exhausted");
    b0 = arBeats;
    e = '{data: 32'h0, status: 2'b10, attempts: 16'(POLL_MAX)};
    applyStimulus(2'd2, 32'h1000, 32'h1, 32'h1, 4'h0, 1, e);
    waitResponse(0, 0, lat);
    checkOutput("pollmax_ar_beats", arBeats - b0, POLL_MAX);

    $display("[TB] READ SLVERR with stalled rsp_ready");
    slvRresp = 2'b10;
    rdQueue.push_back(32'hBAD0BAD0);
    e = '{data: 32'hBAD0BAD0, status: 2'b01, attempts: 16'd1};
    applyStimulus(2'd0, 32'h1010, 32'h0, 32'h0, 4'h0, 1, e);
    waitResponse(0, 5, lat);
    slvRresp = 2'b00;

    $display("[TB] random READ/WRITE mix");
    for (int i = 0; i < 6; i++) begin
      op = 2'($urandom_range(0, 1));
      d  = $urandom;
      a  = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
      if (op == 2'd0) begin
        rdQueue.push_back(d);
        e = '{data: d, status: 2'b00, attempts: 16'd1};
      end else begin
        e = '{data: 32'h0, status: 2'b00, attempts: 16'd0};
      end
      applyStimulus(op, a, d, 32'h0, 4'hF, 1, e);
      waitResponse(0, 0, lat);
      checkOutput("mix_latency", lat, 3);
    end

    $display("[TB] stalled AR, watchdog, reset mid-transaction");
    m_axil_arready = 1'b0;
    e = '{data: 32'h0, status: 2'b00, attempts: 16'd0};
    applyStimulus(2'd0, 32'h4444, 32'h0, 32'h0, 4'h0, 0, e);
    firstErr = 0;
    for (k = 1; k <= 30; k++) begin
      @(negedge user_clk);
      if (k == 15) checkOutput("wdog_early", wdog_err, 0);
      if (wdog_err && firstErr == 0) firstErr = k;
    end
    checkOutput("stall_arvalid", m_axil_arvalid, 1);
    checkOutput("stall_busy", busy, 1);
`ifdef AXIL_CMD_MASTER_WDOG_EN
    checkOutput("wdog_set_window", (firstErr >= WDOG_CYC && firstErr <= WDOG_CYC + 2), 1);
    checkOutput("wdog_sticky", wdog_err, 1);
`else
    checkOutput("wdog_tied_low", firstErr, 0);
`endif
    user_reset = 1'b1;
    @(negedge user_clk);
    checkOutput("mrst_arvalid", m_axil_arvalid, 0);
    checkOutput("mrst_araddr", m_axil_araddr, 0);
    checkOutput("mrst_cmd_ready", cmd_ready, 1);
    checkOutput("mrst_busy", busy, 0);
    checkOutput("mrst_wdog", wdog_err, 0);
    checkOutput("mrst_rsp", {rsp_valid, rsp_status, rsp_attempts}, 0);
    user_reset = 1'b0;
    m_axil_arready = 1'b1;

    rdQueue.delete();
    rdQueue.push_back(32'h0BADF00D);
    e = '{data: 32'h0BADF00D, status: 2'b00, attempts: 16'd1};
    applyStimulus(2'd0, 32'h1000, 32'h0, 32'h0, 4'h0, 1, e);
    waitResponse(0, 0, lat);
    checkOutput("post_rst_latency", lat, 3);
    checkOutput("sb_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, errCount);
    $finish;
  end
endmodule
